axi_compression_word_unpacker: RTL
==================================

// Module: axi_compression_word_unpacker
// PURPOSE
//  Downstream stage of the axi_compression AXI4-Lite register slave. Buffers 32-bit
//  words written to the slave data register, unpacks them LSB-byte-first, and presents
//  them as a valid/ready byte stream to the LZW compression core. Returns FIFO level,
//  overflow and emitted-byte count to the slave status registers.
// PARAMETERS
//  FIFO_DEPTH   4    word FIFO entries; power of 2, >= 2
//  CNT_WIDTH    32   width of byte_count
// PORTS
//  ACLK        in   1              clock; all logic on rising edge
//  ARESET      in   1              synchronous active-high reset
//  wr_en       in   1              one-cycle strobe: slave wrote data register
//  wr_data     in   32             word; byte 0 = wr_data[7:0], emitted first
//  wr_nbytes   in   2              valid bytes in word, low-aligned; 2'b00 means 4
//  wr_last     in   1              word ends the compression block
//  clr         in   1              synchronous soft clear from slave control bit
//  m_byte      out  8              stream byte
//  m_valid     out  1              m_byte valid
//  m_last      out  1              final byte of a block
//  m_ready     in   1              core accepts byte when m_valid & m_ready
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  words stored in FIFO (excludes unpacker word)
//  fifo_full   out  1              fifo_count == FIFO_DEPTH
//  overflow    out  1              sticky: a write was dropped
//  busy        out  1              FIFO non-empty or unpacker holds a word
//  byte_count  out  CNT_WIDTH      bytes accepted by the core since reset/clr
// BEHAVIOUR
//  Reset (ARESET=1 at edge): FIFO emptied, unpacker -> IDLE; m_valid=0, m_last=0,
//   m_byte=0, fifo_count=0, fifo_full=0, overflow=0, busy=0, byte_count=0.
//   Reset mid-word discards remaining bytes; no partial-flush.
//  clr: identical effect to ARESET; ARESET has priority; wr_en in a clr cycle is ignored.
//  FIFO entry = {wr_data, nbytes(1..4), wr_last}. Write accepted when wr_en & (!fifo_full
//   | pop this cycle). Write while full without pop: word dropped, overflow set (sticky
//   until reset/clr). Simultaneous write+pop: fifo_count unchanged.
//  Unpacker FSM:
//   IDLE : m_valid=0. If FIFO non-empty: pop head, load shift reg, rem=nbytes,
//          lst=last -> SHIFT.
//   SHIFT: m_valid=1, m_byte=shift[7:0], m_last = lst & (rem==1).
//          On handshake: byte_count+1 (wraps mod 2^CNT_WIDTH), shift>>=8, rem-1.
//          If rem==1 at handshake: FIFO non-empty -> pop+load next word same edge
//          (stay SHIFT, zero bubbles); else -> IDLE.
//  Latency: wr_en sampled at edge E0 into empty FIFO with IDLE unpacker -> m_valid=1
//   after edge E1. Sustained throughput 1 byte/cycle while m_ready=1.
//  m_byte/m_last held stable while m_valid & !m_ready (AXI-Stream rule); m_valid never
//   drops without handshake except on reset/clr.
//  busy = (fifo_count!=0) | (state==SHIFT). fifo_full/fifo_count registered, updated
//   at the same edge as the write/pop.
//  Bytes above nbytes in wr_data are ignored and never emitted.
// TESTING
//  1. wr 0x44332211, nbytes=0, last=1, m_ready=1 -> bytes 11,22,33,44 on 4 consecutive
//     cycles from E1, m_last only on 44, byte_count=4, busy=0 after.
//  2. wr 0xAABBCCDD nbytes=2 last=0, then 0x000000EE nbytes=1 last=1 -> DD,CC,EE;
//     m_last on EE only; AA/BB never appear.
//  3. m_ready=0, 5 writes with FIFO_DEPTH=4 -> first word in unpacker, 4 in FIFO,
//     fifo_full=1, overflow=0; 6th write -> overflow=1, fifo_count stays 4.
//  4. FIFO full, m_ready=1, wr_en on cycle unpacker pops -> write accepted,
//     fifo_count stays 4, overflow stays 0.
//  5. m_ready toggled 1010..., 3 full words queued -> 12 bytes in order, m_byte stable
//     while stalled, no bubble between words when m_ready=1.
//  6. ARESET (then separately clr) asserted after 2 of 4 bytes accepted -> next cycle
//     m_valid=0, fifo_count=0, byte_count=0, overflow=0; remaining bytes never emitted.

Source files
------------

// File: rtl/axi_compression_word_unpacker.sv
// -----------------------------------------------------------------------------
// axi_compression_word_unpacker
//
// Purpose
//   Sits behind the axi_compression AXI4-Lite register slave. Each write to the
//   slave data register lands here as a 32-bit word with a valid-byte count and
//   a block-end flag. Words are buffered in a small FIFO, then unpacked
//   LSB-byte-first into a valid/ready byte stream for the LZW compression core.
//   FIFO level, a sticky overflow flag and an accepted-byte counter are returned
//   to the slave status registers.
//
// Handshake (stream side)
//   A byte transfers on a rising ACLK edge where m_valid & m_ready are both 1.
//   Once m_valid is raised, m_byte and m_last stay unchanged and m_valid stays
//   high until that transfer happens. Only ARESET or clr can withdraw m_valid.
//
// Ports
//   ACLK, ARESET      clock, synchronous active-high reset
//   wr_en             one-cycle strobe: a word is offered
//   wr_data           word; byte 0 = wr_data[7:0], emitted first
//   wr_nbytes         valid bytes, low-aligned; 2'b00 means 4
//   wr_last           the word ends a compression block
//   clr               synchronous soft clear, same effect as ARESET
//   m_byte/m_valid/m_last/m_ready   byte stream to the core
//   fifo_count        words held in the FIFO (the unpacker word is not counted)
//   fifo_full         fifo_count == FIFO_DEPTH
//   overflow          sticky: a write was dropped because the FIFO was full
//   busy              FIFO non-empty or unpacker holds a word
//   byte_count        bytes accepted by the core since reset/clr (wraps)
//   o_dbg_state       unpacker FSM state (0 = IDLE, 1 = SHIFT)
// -----------------------------------------------------------------------------
module axi_compression_word_unpacker #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          wr_en,
  input  logic [31:0]                   wr_data,
  input  logic [1:0]                    wr_nbytes,
  input  logic                          wr_last,
  input  logic                          clr,
  output logic [7:0]                    m_byte,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          byte_count,
  output logic                          o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0]    r_mem_data [FIFO_DEPTH];
  logic [2:0]     r_mem_nb   [FIFO_DEPTH];
  logic           r_mem_last [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_full;
  logic           r_overflow;

  state_t         r_state;
  state_t         w_next_state;
  logic [31:0]    r_shift;
  logic [2:0]     r_rem;
  logic           r_lst;
  logic [CNT_WIDTH-1:0] r_byte_count;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic           w_clear;
  logic           w_fifo_empty;
  logic           w_hs;
  logic           w_last_beat;
  logic           w_pop;
  logic           w_push;
  logic           w_drop;
  logic [2:0]     w_nb_in;
  logic [31:0]    w_wr_masked;
  logic [AW:0]    w_count_next;

  assign w_clear      = ARESET | clr;
  assign w_fifo_empty = (r_count == '0);
  assign w_hs         = (r_state == S_SHIFT) & m_ready;
  assign w_last_beat  = w_hs & (r_rem == 3'd1);

  // A full FIFO still accepts a write on the edge where the unpacker pops,
  // since a slot frees up at that same edge.
  assign w_push = wr_en & ~w_clear & (~r_full | w_pop);
  assign w_drop = wr_en & ~w_clear & r_full & ~w_pop;

  // Count encoding: 2'b00 on the bus means a full word.
  assign w_nb_in = (wr_nbytes == 2'd0) ? 3'd4 : {1'b0, wr_nbytes};

  // Zero the unused upper bytes at write time. The shifter then drains to
  // zero after the last valid byte, so m_byte idles at 0 and bytes above
  // nbytes can never leak onto the stream.
  always_comb begin
    w_wr_masked = wr_data;
    case (wr_nbytes)
      2'd1:    w_wr_masked = {24'h000000, wr_data[7:0]};
      2'd2:    w_wr_masked = {16'h0000, wr_data[15:0]};
      2'd3:    w_wr_masked = {8'h00, wr_data[23:0]};
      default: w_wr_masked = wr_data;
    endcase
  end

  // Unpacker next-state and pop decision.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Reload on the final beat so back-to-back words have no bubble.
        if (w_last_beat) begin
          if (!w_fifo_empty) begin
            w_pop = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (w_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  // Entry storage has no reset: contents are qualified by r_count.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_wr_masked;
      r_mem_nb[r_wr_ptr]   <= w_nb_in;
      r_mem_last[r_wr_ptr] <= wr_last;
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= AW'(r_wr_ptr + 1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= AW'(r_rd_ptr + 1'b1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == (AW+1)'(FIFO_DEPTH));
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Unpacker datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (w_clear) begin
      r_shift      <= '0;
      r_rem        <= '0;
      r_lst        <= 1'b0;
      r_byte_count <= '0;
    end else begin
      // A pop only happens in IDLE or on the final beat, so loading the next
      // word takes precedence over shifting the finished one.
      if (w_pop) begin
        r_shift <= r_mem_data[r_rd_ptr];
        r_rem   <= r_mem_nb[r_rd_ptr];
        r_lst   <= r_mem_last[r_rd_ptr];
      end else if (w_hs) begin
        r_shift <= {8'h00, r_shift[31:8]};
        r_rem   <= r_rem - 3'd1;
      end
      if (w_hs) begin
        r_byte_count <= r_byte_count + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_valid     = (r_state == S_SHIFT);
  assign m_byte      = r_shift[7:0];
  assign m_last      = m_valid & r_lst & (r_rem == 3'd1);
  assign fifo_count  = r_count;
  assign fifo_full   = r_full;
  assign overflow    = r_overflow;
  assign busy        = (r_count != '0) | m_valid;
  assign byte_count  = r_byte_count;
  assign o_dbg_state = r_state;

endmodule
